countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, giving clk cycles per countdown step (simulation uses 4).
REQ-002 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port sw, input, 4, the BCD value for a digit load.
REQ-005 SHALL have port sel, input, 3, the digit select: 0..5 maps to d1..d6.
REQ-006 SHALL have ports load, start, pause and clear, each input, 1, raw button levels asynchronous to clk.
REQ-007 SHALL have ports d1..d6, each output, [0:7], active-low segments a..g then dp; d1 is the least-significant digit.
REQ-008 SHALL have port running, output, 1, high in RUN.
REQ-009 SHALL have port done, output, 1, high in DONE.

Function
REQ-010 SHALL pass each button input through a 2-flop synchronizer, then a rising-edge detector; the resulting event acts on the 3rd clk edge after the input rises.
REQ-011 SHALL resolve simultaneous events with priority clear > load > start > pause; at most one event acts per cycle.
REQ-012 SHALL implement the FSM states IDLE, RUN, PAUSE and DONE.
REQ-013 IDLE: a load writes sw to the digit at sel; sel 6 or 7 is ignored; sw > 9 is stored as 9.
REQ-014 IDLE: start goes to RUN if the 6-digit value is nonzero; if the value is zero, start goes to DONE.
REQ-015 RUN: on each tick, the block SHALL decrement the 6-digit BCD value by 1, with borrow rippling d1→d6 and each borrowing digit 0 becoming 9.
REQ-016 RUN: a tick that yields 000000 SHALL enter DONE in the same cycle as the digit update.
REQ-017 RUN: pause goes to PAUSE; the prescaler holds its count.
REQ-018 PAUSE: start or pause returns to RUN; the prescaler resumes from its held count with no tick lost or added.
REQ-019 A load in RUN or PAUSE SHALL be ignored, and so SHALL a start in RUN or DONE.
REQ-020 DONE: digits stay 000000; a load writes the digit and goes to IDLE.
REQ-021 clear SHALL, from any state, zero all digits and the prescaler and go to IDLE.
REQ-022 SHALL implement the prescaler as a counter 0..TICK_DIV-1, advancing only in RUN; it SHALL emit a one-cycle tick when it wraps from TICK_DIV-1 to 0.
REQ-023 SHALL zero the prescaler on the IDLE→RUN transition.
REQ-024 SHALL register the segment outputs, one cycle after the digit register; encoding (segments a..g, dp, 0 = lit): 0→00000011, 1→10011111, 2→00100101, 3→00001101, 4→10011001, 5→01001001, 6→01000001, 7→00011111, 8→00000001, 9→00001001; any other value → 11111111.
REQ-025 SHALL register running and done, decoded from the state register with no added latency.

Reset
REQ-026 rst_n low SHALL asynchronously set state IDLE, all digits 0, prescaler 0, synchronizers and edge registers 0, d1..d6 = 00000011, running = 0 and done = 0.
REQ-027 Reset deassertion SHALL be synchronized inside the block; the first event is accepted no earlier than the 3rd clk edge after release.
REQ-028 A button held high through reset release SHALL NOT generate an event.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, the digit count 6, and the 7-segment pattern constants, including blank.
REQ-030 The encoder SHALL be a sub-module, sev_seg_enc, with a 4-bit BCD input and an [0:7] segment output; it is instantiated six times.

Verification (TICK_DIV=4)
REQ-031 Load digits so d2=1, d1=2 (value 12), then start: d1 shows 2→1→0 and d2 rolls 1→0 while d1 rolls to 9 ... reaching 000000 after exactly 12 ticks (48 clk); running falls and done rises in the same cycle.
REQ-032 Value 000100 and start: the first tick gives 000099, with borrow across two zero digits.
REQ-033 Pause after 2 ticks, hold 20 clk, then start: 0 decrements occur while paused, and the count resumes with the remaining tick phase intact.
REQ-034 clear and start raised in the same cycle during RUN: IDLE, digits 000000, done=0.
REQ-035 Start with value 000000: DONE on the event cycle; load sw=12, sel=0 gives d1=9 (00001001) and IDLE.
REQ-036 Assert rst_n low mid-RUN asynchronously: outputs reach their reset values immediately, before the next clk edge, and no event fires within 2 clk after release.

Source files
------------

// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the six-digit BCD countdown controller:
// FSM states, button event codes, digit count and 7-segment patterns.
package countdown_ctrl_pkg;

  localparam int NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_CLEAR = 3'd1,
    EV_LOAD  = 3'd2,
    EV_START = 3'd3,
    EV_PAUSE = 3'd4
  } event_e;

  // Button vector bit positions
  localparam int BTN_PAUSE = 0;
  localparam int BTN_START = 1;
  localparam int BTN_LOAD  = 2;
  localparam int BTN_CLEAR = 3;
  localparam int NUM_BTNS  = 4;

  // Segment order a..g then dp, 0 = lit
  localparam logic [0:7] SEG_0     = 8'b00000011;
  localparam logic [0:7] SEG_1     = 8'b10011111;
  localparam logic [0:7] SEG_2     = 8'b00100101;
  localparam logic [0:7] SEG_3     = 8'b00001101;
  localparam logic [0:7] SEG_4     = 8'b10011001;
  localparam logic [0:7] SEG_5     = 8'b01001001;
  localparam logic [0:7] SEG_6     = 8'b01000001;
  localparam logic [0:7] SEG_7     = 8'b00011111;
  localparam logic [0:7] SEG_8     = 8'b00000001;
  localparam logic [0:7] SEG_9     = 8'b00001001;
  localparam logic [0:7] SEG_BLANK = 8'b11111111;

  function automatic logic [3:0] bcd_sat(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

endpackage

// File: rtl/countdown_ctrl_sev_seg_enc.sv
// BCD to active-low 7-segment decoder; non-decimal codes blank the digit.
module sev_seg_enc
  import countdown_ctrl_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [0:7] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Six-digit BCD countdown timer: synchronised buttons, IDLE/RUN/PAUSE/DONE
// control, prescaled decrement with borrow ripple and registered segment drive.
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic [2:0] sel,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  output logic [0:7] d1,
  output logic [0:7] d2,
  output logic [0:7] d3,
  output logic [0:7] d4,
  output logic [0:7] d5,
  output logic [0:7] d6,
  output logic       running,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] btn_sync1_q;
  logic [NUM_BTNS-1:0] btn_sync2_q;
  logic [NUM_BTNS-1:0] btn_prev_q;
  logic [NUM_BTNS-1:0] btn_rise;
  logic [2:0]          rst_sync_q;
  logic                rst_ok;
  event_e              ev;

  state_e state_q, state_d;
  logic   running_q, running_d;
  logic   done_q, done_d;

  logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0][3:0] dec_digits;
  logic [NUM_DIGITS-1:0]      borrow;
  logic [NUM_DIGITS-1:0]      dec_nz;
  logic [NUM_DIGITS-1:0]      cur_nz;
  logic                       dec_zero;
  logic                       value_nz;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  logic [0:7] seg_d [NUM_DIGITS];
  logic [0:7] seg_q [NUM_DIGITS];

  assign btn_raw = {clear, load, start, pause};

  // Release is retimed through three flops; the edge register has caught up
  // with any button held across release before events are accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q  <= '0;
      btn_sync1_q <= '0;
      btn_sync2_q <= '0;
      btn_prev_q  <= '0;
    end else begin
      rst_sync_q  <= {rst_sync_q[1:0], 1'b1};
      btn_sync1_q <= btn_raw;
      btn_sync2_q <= btn_sync1_q;
      btn_prev_q  <= btn_sync2_q;
    end
  end

  assign rst_ok   = rst_sync_q[2];
  assign btn_rise = btn_sync2_q & ~btn_prev_q & {NUM_BTNS{rst_ok}};

  always_comb begin
    ev = EV_NONE;
    if (btn_rise[BTN_CLEAR])      ev = EV_CLEAR;
    else if (btn_rise[BTN_LOAD])  ev = EV_LOAD;
    else if (btn_rise[BTN_START]) ev = EV_START;
    else if (btn_rise[BTN_PAUSE]) ev = EV_PAUSE;
  end

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
      if (gi == 0) begin : g_first
        assign borrow[gi] = 1'b1;
      end else begin : g_rest
        assign borrow[gi] = borrow[gi-1] && (digits_q[gi-1] == 4'd0);
      end
      assign dec_digits[gi] = !borrow[gi]           ? digits_q[gi] :
                              (digits_q[gi] == 4'd0) ? 4'd9 :
                                                       digits_q[gi] - 4'd1;
      assign dec_nz[gi] = |dec_digits[gi];
      assign cur_nz[gi] = |digits_q[gi];
    end
  endgenerate

  assign dec_zero = ~|dec_nz;
  assign value_nz = |cur_nz;

  // State register, with running/done registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ev == EV_START) state_d = value_nz ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        if (tick && dec_zero)   state_d = ST_DONE;
        else if (ev == EV_PAUSE) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (ev == EV_START || ev == EV_PAUSE) state_d = ST_RUN;
      end
      ST_DONE: begin
        if (ev == EV_LOAD) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ev == EV_CLEAR) state_d = ST_IDLE;
  end

  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  assign running = running_q;
  assign done    = done_q;

  always_comb begin
    digits_d = digits_q;
    presc_d  = presc_q;
    if (ev == EV_CLEAR) begin
      digits_d = '0;
      presc_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ev == EV_LOAD) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (sel == 3'(i)) digits_d[i] = bcd_sat(sw);
            end
          end
          if (state_q == ST_IDLE && ev == EV_START && value_nz) presc_d = '0;
        end
        ST_RUN: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick) digits_d = dec_digits;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      presc_q  <= '0;
    end else begin
      digits_q <= digits_d;
      presc_q  <= presc_d;
    end
  end

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
      sev_seg_enc u_enc (
        .bcd_i (digits_q[gi]),
        .seg_o (seg_d[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= SEG_0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) seg_q[i] <= seg_d[i];
    end
  end

  assign d1 = seg_q[0];
  assign d2 = seg_q[1];
  assign d3 = seg_q[2];
  assign d4 = seg_q[3];
  assign d5 = seg_q[4];
  assign d6 = seg_q[5];

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: an integer-valued reference model checked every
// cycle, plus literal expectations for the key countdown scenarios.
module tb_countdown_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = '0;
  logic [2:0] sel = '0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [0:7] d1, d2, d3, d4, d5, d6;
  logic       running, done;

  always #5 clk = ~clk;

  countdown_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .sel(sel),
    .load(load), .start(start), .pause(pause), .clear(clear),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .running(running), .done(done)
  );

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input int v);
    case (v)
      0: return 8'b00000011;
      1: return 8'b10011111;
      2: return 8'b00100101;
      3: return 8'b00001101;
      4: return 8'b10011001;
      5: return 8'b01001001;
      6: return 8'b01000001;
      7: return 8'b00011111;
      8: return 8'b00000001;
      9: return 8'b00001001;
      default: return 8'b11111111;
    endcase
  endfunction

  function automatic int p10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    return p;
  endfunction

  function automatic int dig(input int v, input int i);
    return (v / p10(i)) % 10;
  endfunction

  // Reference model: value as an integer, state as 0 idle / 1 run / 2 pause / 3 done.
  // A button acts on the 3rd edge after it rises, and only from the 4th edge after release.
  int       m_st = 0, m_val = 0, m_presc = 0, m_disp = 0, m_ecount = 0;
  int       m_sel_ev, m_old, m_v;
  bit       m_tick;
  logic [3:0] m_hist [4];
  logic [3:0] m_lv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_val = 0; m_presc = 0; m_disp = 0; m_ecount = 0;
      for (int b = 0; b < 4; b++) m_hist[b] = '0;
    end else begin
      m_ecount++;
      m_lv = {pause, start, load, clear};
      m_sel_ev = -1;
      for (int b = 0; b < 4; b++) begin
        if (m_sel_ev < 0 && m_hist[b][1] && !m_hist[b][2] && m_ecount >= 4) m_sel_ev = b;
      end
      for (int b = 0; b < 4; b++) m_hist[b] = {m_hist[b][2:0], m_lv[b]};
      m_old = m_val;
      m_tick = (m_st == 1) && (m_presc == TD - 1);
      if (m_sel_ev == 0) begin
        m_val = 0; m_presc = 0; m_st = 0;
      end else begin
        case (m_st)
          0, 3: begin
            if (m_sel_ev == 1) begin
              if (int'(sel) < 6) begin
                m_v = (int'(sw) > 9) ? 9 : int'(sw);
                m_val = m_val - dig(m_val, int'(sel)) * p10(int'(sel)) + m_v * p10(int'(sel));
              end
              if (m_st == 3) m_st = 0;
            end else if (m_sel_ev == 2 && m_st == 0) begin
              if (m_val != 0) begin m_st = 1; m_presc = 0; end
              else m_st = 3;
            end
          end
          1: begin
            m_presc = m_tick ? 0 : m_presc + 1;
            if (m_tick) m_val--;
            if (m_tick && m_val == 0) m_st = 3;
            else if (m_sel_ev == 3) m_st = 2;
          end
          2: begin
            if (m_sel_ev == 2 || m_sel_ev == 3) m_st = 1;
          end
          default: ;
        endcase
      end
      m_disp = m_old;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_d1", d1, seg_of(dig(m_disp, 0)));
      check("m_d2", d2, seg_of(dig(m_disp, 1)));
      check("m_d3", d3, seg_of(dig(m_disp, 2)));
      check("m_d4", d4, seg_of(dig(m_disp, 3)));
      check("m_d5", d5, seg_of(dig(m_disp, 4)));
      check("m_d6", d6, seg_of(dig(m_disp, 5)));
      check("m_running", running, (m_st == 1));
      check("m_done", done, (m_st == 3));
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: clear = v;
      1: load  = v;
      2: start = v;
      default: pause = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (4) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic load_digit(input int s, input int v);
    @(negedge clk);
    sel = 3'(s);
    sw  = 4'(v);
    press(1);
  endtask

  // what: 0 = running high, 1 = done high
  task automatic wait_for(input int what, input int limit, output int n);
    n = 0;
    while (((what == 0) ? running : done) !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) check($sformatf("wait_%0d_timeout", what), 32'(n), 32'(limit - 1));
  endtask

  // Raise start at a negedge and return at the first negedge showing running
  task automatic start_run();
    int n;
    @(negedge clk);
    start = 1'b1;
    wait_for(0, 20, n);
    start = 1'b0;
  endtask

  initial begin
    int n;
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_d1", d1, 8'b00000011);
    check("rst_d6", d6, 8'b00000011);
    check("rst_running", running, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Value 12 counts down to zero in 12 ticks
    load_digit(0, 2);
    load_digit(1, 1);
    check("ld12_d1", d1, 8'b00100101);
    check("ld12_d2", d2, 8'b10011111);
    start_run();
    $display("txn start value=12");
    wait_for(1, 200, n);
    check("cnt12_cycles", 32'(n), 32'd48);
    check("cnt12_run_low", running, 1'b0);
    @(negedge clk);
    check("cnt12_d1", d1, 8'b00000011);
    check("cnt12_d2", d2, 8'b00000011);

    // Start from zero, then load saturates into DONE and returns to IDLE
    press(0);
    press(2);
    $display("txn start value=0");
    check("zero_done", done, 1'b1);
    load_digit(0, 12);
    $display("txn load sel=0 sw=12");
    check("sat_d1", d1, 8'b00001001);
    check("sat_done", done, 1'b0);
    load_digit(6, 7);
    load_digit(1, 15);
    check("sat_d2", d2, 8'b00001001);
    press(0);

    // 000100 borrows across two zero digits
    load_digit(2, 1);
    start_run();
    $display("txn start value=100");
    repeat (5) @(negedge clk);
    check("b100_d1", d1, 8'b00001001);
    check("b100_d2", d2, 8'b00001001);
    check("b100_d3", d3, 8'b00000011);
    press(0);

    // Pause after two ticks, hold, resume with phase intact
    load_digit(0, 5);
    start_run();
    $display("txn start value=5");
    repeat (6) @(negedge clk);
    pause = 1'b1;
    repeat (4) @(negedge clk);
    pause = 1'b0;
    $display("txn pause");
    check("pause_running", running, 1'b0);
    check("pause_d1", d1, 8'b00001101);
    repeat (20) @(negedge clk);
    check("pause_hold_d1", d1, 8'b00001101);
    start_run();
    $display("txn resume");
    wait_for(1, 100, n);
    check("resume_cycles", 32'(n), 32'd11);
    press(0);

    // clear and start together during RUN
    load_digit(1, 3);
    start_run();
    repeat (3) @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    repeat (4) @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    $display("txn clear+start in run");
    check("clr_running", running, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_d2", d2, 8'b00000011);

    // Asynchronous reset mid-RUN with start held through release
    load_digit(0, 8);
    start_run();
    repeat (6) @(negedge clk);
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    $display("txn async reset");
    check("arst_d1", d1, 8'b00000011);
    check("arst_running", running, 1'b0);
    check("arst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("held_no_event", running | done, 1'b0);
    start = 1'b0;
    press(2);
    $display("txn start after reset");
    check("post_rst_done", done, 1'b1);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running time want finish");
    $fatal(1, "timeout");
  end

endmodule
